// File: rtl/vga_timing_gen.sv
// Raster timing generator for the sprite engine. It produces the pixel position, sync and
// visible flags, and line/frame strobes, all stepped by a pixel-enable strobe.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       polarity,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  // Both totals must fit the 10-bit counters (at most 1024).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  // The window bounds are 11 bits wide so that an end bound of 1024 can still be represented.
  localparam logic [10:0] H_VIS_END = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS_END = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEGIN  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEGIN  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic       x_wrap;
  logic       y_wrap;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       h_act;
  logic       v_act;
  logic       vis_next;

  // Decoding from the next-state position keeps the registered flags aligned with pix_x/pix_y.
  always_comb begin
    x_wrap = pix_en && (pix_x == H_LAST);
    y_wrap = x_wrap && (pix_y == V_LAST);
    x_next = pix_x;
    y_next = pix_y;
    if (pix_en) x_next = x_wrap ? 10'd0 : pix_x + 10'd1;
    if (x_wrap) y_next = y_wrap ? 10'd0 : pix_y + 10'd1;
    h_act    = ({1'b0, x_next} >= HS_BEGIN) && ({1'b0, x_next} < HS_END);
    v_act    = ({1'b0, y_next} >= VS_BEGIN) && ({1'b0, y_next} < VS_END);
    vis_next = ({1'b0, x_next} < H_VIS_END) && ({1'b0, y_next} < V_VIS_END);
  end

  // Polarity is applied every clock, so a change shows up without waiting for pix_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      visible     <= 1'b1;
      hsync       <= ~polarity;
      vsync       <= ~polarity;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      pix_x       <= x_next;
      pix_y       <= y_next;
      visible     <= vis_next;
      hsync       <= h_act ? polarity : ~polarity;
      vsync       <= v_act ? polarity : ~polarity;
      line_start  <= x_wrap;
      frame_start <= y_wrap;
      if (y_wrap) frame_count <= frame_count + 8'd1;
    end
  end

endmodule
